// File: rtl/raiz_sched.sv
// Two-requester scheduler around a digit-by-digit integer square root (q = floor(sqrt(a)), r = a - q*q).
// Arbitration is fixed priority to req0 by default; define RAIZ_SCHED_RR_EN for round-robin arbitration.
module raiz_sched #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0,
  input  logic [N-1:0]   a0,
  input  logic           req1,
  input  logic [N-1:0]   a1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           busy,
  output logic           done,
  output logic           id,
  output logic [N/2-1:0] q,
  output logic [N/2:0]   r
);

  localparam int H  = N / 2;
  localparam int RW = H + 2;
  localparam int CW = $clog2(H) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  opnd;
  logic [RW-1:0] rem;
  logic [H-1:0]  qacc;
  logic [CW-1:0] cnt;
  logic          cur_id;
  logic          sel;

  logic [RW-1:0] rem_sh;
  logic [RW-1:0] trial;
  logic [RW-1:0] rem_nx;
  logic [H-1:0]  qacc_nx;
  logic          ge;
  logic          last;

`ifdef RAIZ_SCHED_RR_EN
  logic ptr;
  assign sel = (req0 && req1) ? ptr : req1;
`else
  assign sel = ~req0;
`endif

  // Stored rem never exceeds 2*qacc, so its top two bits are zero before every shift.
  assign rem_sh  = RW'({rem, opnd[N-1:N-2]});
  assign trial   = {qacc, 2'b01};
  assign ge      = (rem_sh >= trial);
  assign rem_nx  = ge ? (rem_sh - trial) : rem_sh;
  assign qacc_nx = {qacc[H-2:0], ge};
  assign last    = (cnt == CW'(H - 1));

  assign busy = (state == S_CALC) || (state == S_DONE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      opnd   <= '0;
      rem    <= '0;
      qacc   <= '0;
      cnt    <= '0;
      cur_id <= 1'b0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      id     <= 1'b0;
      q      <= '0;
      r      <= '0;
`ifdef RAIZ_SCHED_RR_EN
      ptr    <= 1'b0;
`endif
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            state  <= S_CALC;
            opnd   <= sel ? a1 : a0;
            cur_id <= sel;
            gnt0   <= ~sel;
            gnt1   <= sel;
            rem    <= '0;
            qacc   <= '0;
            cnt    <= '0;
`ifdef RAIZ_SCHED_RR_EN
            ptr    <= ~sel;
`endif
          end
        end
        S_CALC: begin
          rem  <= rem_nx;
          qacc <= qacc_nx;
          opnd <= {opnd[N-3:0], 2'b00};
          cnt  <= cnt + 1'b1;
          if (last) begin
            state <= S_DONE;
            q     <= qacc_nx;
            r     <= rem_nx[H:0];
            id    <= cur_id;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raiz_sched.sv
// Randomized and directed bench for raiz_sched against an arithmetic sqrt and arbitration model.
module tb_raiz_sched;
  localparam int N = 8;
  localparam int H = N / 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1;
  logic [N-1:0] a0, a1;
  logic         gnt0, gnt1, busy, done, id;
  logic [H-1:0] q;
  logic [H:0]   r;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int last_done_cyc = 0;
  bit ptr_m  = 1'b0;

  raiz_sched #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .req1(req1), .a1(a1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .id(id), .q(q), .r(r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int isqrt(input int a);
    int s = 0;
    while ((s + 1) * (s + 1) <= a) s++;
    return s;
  endfunction

  function automatic bit pick(input bit r0, input bit r1);
`ifdef RAIZ_SCHED_RR_EN
    if (r0 && r1) return ptr_m;
`else
    if (r0 && r1) return 1'b0;
`endif
    return r1;
  endfunction

  // chgv >= 0 overwrites both operands with that value while the operation runs.
  task automatic do_op(input bit r0, input bit r1, input int x0, input int x1,
                       input int chgv, input bit drop, input bit hold, input string tag);
    bit w;
    bit seen;
    int opv, lat, qe, gap;
    @(negedge clk);
    req0 = r0; req1 = r1; a0 = N'(x0); a1 = N'(x1);
    w   = pick(r0, r1);
    opv = w ? x1 : x0;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk);
      if (gnt0 || gnt1) seen = 1'b1;
    end
    if (!seen) begin
      chk({tag, "_gnt_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_gnt0"}, int'(gnt0), int'(!w));
    chk({tag, "_gnt1"}, int'(gnt1), int'(w));
    chk({tag, "_busy"}, int'(busy), 1);
    ptr_m = !w;
    if (chgv >= 0) begin a0 = N'(chgv); a1 = N'(chgv); end
    if (drop) begin if (w) req1 = 1'b0; else req0 = 1'b0; end
    lat = 0; seen = 1'b0;
    for (int k = 1; k <= H + 3 && !seen; k++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; lat = k; end
    end
    chk({tag, "_latency"}, lat, H);
    qe = isqrt(opv);
    chk({tag, "_q"},  int'(q),  qe);
    chk({tag, "_r"},  int'(r),  opv - qe * qe);
    chk({tag, "_id"}, int'(id), int'(w));
    gap = cyc - last_done_cyc;
    last_done_cyc = cyc;
    if (hold && r0 && r1) chk({tag, "_b2b_gap"}, gap, H + 2);
    if (!hold) begin if (w) req1 = 1'b0; else req0 = 1'b0; end
  endtask

  initial begin
    int dcount;
    bit rr0, rr1;
    int x0, x1, cv;
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0; a0 = '0; a1 = '0;
    #3 rst_n = 1'b0;
    #3;
    chk("rst_gnt0", int'(gnt0), 0); chk("rst_gnt1", int'(gnt1), 0);
    chk("rst_busy", int'(busy), 0); chk("rst_done", int'(done), 0);
    chk("rst_id", int'(id), 0); chk("rst_q", int'(q), 0); chk("rst_r", int'(r), 0);
    @(negedge clk); rst_n = 1'b1;

    do_op(1, 0, 0,   0,   -1, 0, 0, "zero");
    do_op(0, 1, 0,   200, -1, 0, 0, "a200");
    do_op(0, 1, 0,   255, -1, 0, 0, "a255");
    do_op(0, 1, 0,   24,  -1, 0, 0, "a24");
    do_op(1, 0, 255, 0,   -1, 0, 0, "a0max");
    do_op(1, 0, 144, 0,   3,  0, 0, "latch");
    do_op(1, 0, 99,  0,   -1, 1, 0, "drop");

    // Contention with both requests held across consecutive operations.
    do_op(1, 1, 50, 99, -1, 0, 1, "cont1");
    do_op(1, 1, 50, 99, -1, 0, 1, "cont2");
    do_op(1, 1, 50, 99, -1, 0, 0, "cont3");
    @(negedge clk); req0 = 1'b0; req1 = 1'b0;
    repeat (H + 3) @(negedge clk);

    // Asynchronous reset in the second CALC cycle aborts the operation.
    req0 = 1'b1; a0 = N'(77);
    @(negedge clk);
    chk("abort_gnt0", int'(gnt0), 1);
    @(negedge clk);
    rst_n = 1'b0; req0 = 1'b0; ptr_m = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0); chk("abort_done", int'(done), 0);
    chk("abort_gnt0_low", int'(gnt0), 0); chk("abort_q", int'(q), 0);
    chk("abort_r", int'(r), 0); chk("abort_id", int'(id), 0);
    @(negedge clk); rst_n = 1'b1;
    dcount = 0;
    for (int k = 0; k < H + 4; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    do_op(1, 0, 77, 0, -1, 0, 0, "after_rst");

    for (int i = 0; i < 30; i++) begin
      rr0 = 1'($urandom_range(0, 1));
      rr1 = rr0 ? 1'($urandom_range(0, 1)) : 1'b1;
      x0  = (i % 7 == 0) ? 255 : int'($urandom_range(0, 255));
      x1  = (i % 5 == 0) ? 0   : int'($urandom_range(0, 255));
      cv  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1;
      do_op(rr0, rr1, x0, x1, cv, 1'($urandom_range(0, 1)), 0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/raiz_sched.md
RAIZ_SCHED -- requirements
Module: raiz_sched

Interface
REQ-001 Parameter: N, default 8, operand width (even, 4..16); result width N/2, remainder width N/2+1.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst_n  input  1  asynchronous reset, active-low.
REQ-004 req0  input  1  requester 0 operation request, held until done with id=0.
REQ-005 a0  input  N  requester 0 radicand.
REQ-006 req1  input  1  requester 1 operation request, held until done with id=1.
REQ-007 a1  input  N  requester 1 radicand.
REQ-008 gnt0  output  1  one-cycle pulse, requester 0 accepted.
REQ-009 gnt1  output  1  one-cycle pulse, requester 1 accepted.
REQ-010 busy  output  1  high in CALC and DONE.
REQ-011 done  output  1  one-cycle pulse, result valid.
REQ-012 id  output  1  requester owning current/last result.
REQ-013 q  output  N/2  floor(sqrt(operand)).
REQ-014 r  output  N/2+1  operand - q*q.

Function
REQ-015 FSM states IDLE, CALC, DONE; IDLE->CALC on any req sampled high; CALC->DONE after exactly N/2 CALC cycles; DONE->IDLE unconditionally.
REQ-016 On the IDLE->CALC edge, the selected operand and requester index are latched; later changes to a0/a1 have no effect on the running operation.
REQ-017 gnt0/gnt1 high only in the first CALC cycle, for the selected requester, never both.
REQ-018 Iteration per CALC cycle, MSB pair first: rem = (rem<<2) | next 2 operand bits; trial = (qacc<<2)|1; if rem >= trial then rem -= trial, qacc = (qacc<<1)|1, else qacc = qacc<<1.
REQ-019 Internal rem/trial arithmetic N/2+2 bits wide; no truncation of intermediate values.
REQ-020 done high exactly in the DONE cycle, N/2 cycles after gnt; q, r, id update on entry to DONE and hold until the next DONE.
REQ-021 Back-to-back operations take N/2+2 cycles each; a req high in the DONE cycle is not sampled until IDLE.
REQ-022 req deasserted during CALC: operation completes and done still pulses.
REQ-023 Both req high in IDLE: winner per REQ-031/REQ-032; loser keeps waiting, no gnt.
REQ-024 Operand 0 yields q=0, r=0; operand 2^N-1 yields q=2^(N/2)-1, r=2^(N/2+1)-2.

Reset
REQ-025 rst_n low forces state IDLE immediately, independent of clk.
REQ-026 Reset values: gnt0=0, gnt1=0, busy=0, done=0, id=0, q=0, r=0, round-robin pointer=0.
REQ-027 Reset during CALC or DONE aborts the operation; no done pulse for it after release.
REQ-028 First sampling edge is the first rising clk with rst_n high.

Configuration
REQ-029 Macro RAIZ_SCHED_RR_EN selects the arbitration policy.
REQ-030 Pointer register exists only when RAIZ_SCHED_RR_EN is defined.
REQ-031 With RAIZ_SCHED_RR_EN: on contention the requester equal to the pointer wins; pointer toggles to the other requester after every grant.
REQ-032 Without RAIZ_SCHED_RR_EN: fixed priority, req0 always wins contention.

Verification
REQ-033 N=8, req0=1 a0=0 -> gnt0 pulse, done 4 cycles later, q=0 r=0 id=0.
REQ-034 req1=1 a1=200 -> gnt1 pulse, done 4 cycles after gnt1, q=14 r=4 id=1; a1=255 -> q=15 r=30; a1=24 -> q=4 r=8.
REQ-035 RR_EN, req0=req1=1 from reset, a0=50 a1=99 -> gnt0 then gnt1, results (7,1,id0) then (9,18,id1), second done 6 cycles after first.
REQ-036 No RR_EN, req0 and req1 held high through 3 operations -> three gnt0, no gnt1.
REQ-037 rst_n pulsed low during second CALC cycle -> all outputs 0 immediately, no done; reapplied request completes normally.
REQ-038 a0 changed from 144 to 3 during CALC -> q=12 r=0.
